// File: rtl/hazard_scoreboard.sv
// Register scoreboard beside the ID stage: a per-register countdown until each in-flight result
// can be forwarded, used to stall ID on unresolved source operands.
module hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 2,
    parameter int MAX_LAT        = 7,
    parameter int CNT_WIDTH      = $clog2(MAX_LAT + 1),
    parameter int PERF_WIDTH     = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              id_valid,
    input  logic                              id_is_branch,
    input  logic [NUM_SRC-1:0]                id_rs_en,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic                              id_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0]         id_rd_addr,
    input  logic [CNT_WIDTH-1:0]              id_rd_lat,
    input  logic                              id_flush,
    input  logic                              pipe_hold,
    output logic [3:0]                        stall,
    output logic                              sb_busy,
    output logic [PERF_WIDTH-1:0]             stall_cycles
);

    localparam int                   NUM_REGS  = 1 << REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_LAT_C = CNT_WIDTH'(MAX_LAT);

    logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
    logic [PERF_WIDTH-1:0] stall_cycles_q;
    logic [PERF_WIDTH-1:0] stall_cycles_d;
    logic [NUM_SRC-1:0]    src_haz;
    logic [CNT_WIDTH-1:0]  need;
    logic [CNT_WIDTH-1:0]  issue_lat;
    logic                  hazard;
    logic                  issue;
    logic                  freeze;
    logic                  any_busy;

    // Branches consume operands in ID, everything else one cycle later in EX.
    assign need = id_is_branch ? '0 : CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_ADDR_WIDTH-1:0] rs_addr;
            assign rs_addr     = id_rs_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            assign src_haz[gi] = id_rs_en[gi] && (rs_addr != '0) && (cnt_q[rs_addr] > need);
        end
    endgenerate

    assign hazard    = id_valid & (|src_haz);
    assign issue_lat = (id_rd_lat > MAX_LAT_C) ? MAX_LAT_C : id_rd_lat;

    always_comb begin
        stall  = 4'b0000;
        issue  = 1'b0;
        freeze = 1'b0;
        if (!rst_n) begin
            stall = 4'b0000;
        end else if (pipe_hold) begin
            stall  = 4'b1011;
            freeze = 1'b1;
        end else if (id_flush) begin
            stall = 4'b0000;
        end else if (hazard) begin
            stall = 4'b0111;
        end else begin
            issue = id_valid & id_rd_we;
        end
    end

    // Sources are checked against cnt_q, so an instruction's own rd sees the pre-issue count.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!freeze && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
            end
            if (issue && (id_rd_lat != '0) && (id_rd_addr == REG_ADDR_WIDTH'(r))) begin
                cnt_d[r] = issue_lat;
            end
        end
    end

    always_comb begin
        any_busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            any_busy = any_busy | (cnt_q[r] != '0);
        end
    end

    assign sb_busy = rst_n & any_busy;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall != 4'b0000) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each task drives one scenario and checks inline.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_is_branch;
    logic [1:0]  id_rs_en;
    logic [9:0]  id_rs_addr;
    logic        id_rd_we;
    logic [4:0]  id_rd_addr;
    logic [2:0]  id_rd_lat;
    logic        id_flush;
    logic        pipe_hold;
    logic [3:0]  stall;
    logic        sb_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_HAZ  = 4'b0111;
    localparam logic [3:0] S_HOLD = 4'b1011;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_is_branch (id_is_branch),
        .id_rs_en     (id_rs_en),
        .id_rs_addr   (id_rs_addr),
        .id_rd_we     (id_rd_we),
        .id_rd_addr   (id_rd_addr),
        .id_rd_lat    (id_rd_lat),
        .id_flush     (id_flush),
        .pipe_hold    (pipe_hold),
        .stall        (stall),
        .sb_busy      (sb_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic br, input logic [1:0] en,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic we,
                         input logic [4:0] rd, input logic [2:0] lat,
                         input logic fl, input logic hold);
        id_valid     = v;
        id_is_branch = br;
        id_rs_en     = en;
        id_rs_addr   = {rs1, rs0};
        id_rd_we     = we;
        id_rd_addr   = rd;
        id_rd_lat    = lat;
        id_flush     = fl;
        pipe_hold    = hold;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL reset_stall got %b want %b", stall, S_NONE);
        end
        checks++;
        if (sb_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", sb_busy);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_perf got %0d want 0", stall_cycles);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL lu_issue_stall got %b want %b", stall, S_NONE);
        end
        tick();
        checks++;
        if (dut.cnt_q[5] !== 3'd2) begin
            errors++; $display("FAIL lu_cnt5_a got %0d want 2", dut.cnt_q[5]);
        end
        drive(1'b1, 1'b0, 2'b11, 5'd5, 5'd1, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_HAZ) begin
            errors++; $display("FAIL lu_haz got %b want %b", stall, S_HAZ);
        end
        tick();
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL lu_release got %b want %b", stall, S_NONE);
        end
        checks++;
        if (dut.cnt_q[5] !== 3'd1) begin
            errors++; $display("FAIL lu_cnt5_b got %0d want 1", dut.cnt_q[5]);
        end
        tick();
        idle();
        checks++;
        if (dut.cnt_q[5] !== 3'd0 || dut.cnt_q[6] !== 3'd1) begin
            errors++; $display("FAIL lu_after cnt5 %0d cnt6 %0d want 0 1", dut.cnt_q[5], dut.cnt_q[6]);
        end
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++; $display("FAIL lu_perf got %0d want 1", stall_cycles);
        end
        $display("test_load_use done");
    endtask

    task automatic test_load_branch();
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 3'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 2'b11, 5'd7, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stall !== S_HAZ) begin
                errors++; $display("FAIL lb_haz%0d got %b want %b", i, stall, S_HAZ);
            end
            tick();
        end
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL lb_proceed got %b want %b", stall, S_NONE);
        end
        tick();
        idle();
        checks++;
        if (stall_cycles !== 32'd2) begin
            errors++; $display("FAIL lb_perf got %0d want 2", stall_cycles);
        end
        $display("test_load_branch done");
    endtask

    task automatic test_divider_hold();
        int haz_n;
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 3'd6, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 1'b1, 5'd10, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL div_indep got %b want %b", stall, S_NONE);
        end
        tick();
        drive(1'b1, 1'b0, 2'b11, 5'd9, 5'd1, 1'b1, 5'd11, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_HAZ || dut.cnt_q[9] !== 3'd5) begin
            errors++; $display("FAIL div_use stall %b cnt9 %0d want %b 5", stall, dut.cnt_q[9], S_HAZ);
        end
        tick();
        pipe_hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stall !== S_HOLD || dut.cnt_q[9] !== 3'd4) begin
                errors++; $display("FAIL div_hold%0d stall %b cnt9 %0d want %b 4", i, stall, dut.cnt_q[9], S_HOLD);
            end
            tick();
        end
        pipe_hold = 1'b0;
        #1;
        haz_n = 0;
        while (stall === S_HAZ && haz_n < 20) begin
            haz_n++;
            tick();
        end
        checks++;
        if (haz_n !== 3) begin
            errors++; $display("FAIL div_resume haz cycles got %0d want 3", haz_n);
        end
        checks++;
        if (stall !== S_NONE || dut.cnt_q[9] !== 3'd1) begin
            errors++; $display("FAIL div_release stall %b cnt9 %0d want %b 1", stall, dut.cnt_q[9], S_NONE);
        end
        tick();
        idle();
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++; $display("FAIL div_perf got %0d want 7", stall_cycles);
        end
        $display("test_divider_hold done");
    endtask

    task automatic test_x0_disabled();
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 3'd2, 1'b0, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL x0_lw got %b want %b", stall, S_NONE);
        end
        tick();
        checks++;
        if (dut.cnt_q[0] !== 3'd0) begin
            errors++; $display("FAIL x0_cnt got %0d want 0", dut.cnt_q[0]);
        end
        drive(1'b1, 1'b0, 2'b01, 5'd0, 5'd5, 1'b1, 5'd1, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL x0_disabled_src got %b want %b", stall, S_NONE);
        end
        drive(1'b1, 1'b0, 2'b11, 5'd0, 5'd0, 1'b1, 5'd1, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL x0_src got %b want %b", stall, S_NONE);
        end
        tick();
        idle();
        checks++;
        if (dut.cnt_q[0] !== 3'd0 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL x0_final cnt0 %0d perf %0d want 0 0", dut.cnt_q[0], stall_cycles);
        end
        $display("test_x0_disabled done");
    endtask

    task automatic test_waw_flush();
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd6, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 3'd1, 1'b0, 1'b0);
        tick();
        idle();
        checks++;
        if (dut.cnt_q[3] !== 3'd1 || sb_busy !== 1'b1) begin
            errors++; $display("FAIL waw_cnt cnt3 %0d busy %b want 1 1", dut.cnt_q[3], sb_busy);
        end
        tick();
        checks++;
        if (sb_busy !== 1'b0) begin
            errors++; $display("FAIL waw_busy_fall got %b want 0", sb_busy);
        end
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 3'd2, 1'b1, 1'b0);
        checks++;
        if (stall !== S_NONE) begin
            errors++; $display("FAIL flush_stall got %b want %b", stall, S_NONE);
        end
        tick();
        idle();
        checks++;
        if (dut.cnt_q[4] !== 3'd0 || sb_busy !== 1'b0) begin
            errors++; $display("FAIL flush_cnt cnt4 %0d busy %b want 0 0", dut.cnt_q[4], sb_busy);
        end
        $display("test_waw_flush done");
    endtask

    task automatic test_reset_mid_haz();
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 3'd2, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 2'b11, 5'd5, 5'd1, 1'b1, 5'd6, 3'd1, 1'b0, 1'b0);
        checks++;
        if (stall !== S_HAZ || dut.cnt_q[5] !== 3'd2) begin
            errors++; $display("FAIL rst_pre stall %b cnt5 %0d want %b 2", stall, dut.cnt_q[5], S_HAZ);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== S_NONE || sb_busy !== 1'b0) begin
            errors++; $display("FAIL rst_low stall %b busy %b want %b 0", stall, sb_busy, S_NONE);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (stall !== S_NONE || dut.cnt_q[5] !== 3'd0 || stall_cycles !== 32'd0 || sb_busy !== 1'b0) begin
            errors++; $display("FAIL rst_after stall %b cnt5 %0d perf %0d busy %b want %b 0 0 0",
                               stall, dut.cnt_q[5], stall_cycles, sb_busy, S_NONE);
        end
        tick();
        idle();
        $display("test_reset_mid_haz done");
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_load_branch();
        test_divider_hold();
        test_x0_disabled();
        test_waw_flush();
        test_reset_mid_haz();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
